// File: rtl/cordic_cos_sched.sv
// Two-requester scheduler that time-shares one iterative cosine engine.
// Define CORDIC_SCHED_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module cordic_cos_sched #(
    parameter int unsigned W             = 22,
    parameter int unsigned ENGINE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_angle,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_angle,
    output logic         req1_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_cos,
    output logic         eng_reset,
    output logic         eng_clk_en,
    output logic [W-1:0] eng_angle,
    input  logic [W-1:0] eng_cos,
    output logic         busy
);

    localparam int unsigned CW = (ENGINE_CYCLES > 1) ? $clog2(ENGINE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [W-1:0]  angle_q;
    logic [W-1:0]  result_q;
    logic [CW-1:0] cnt_q;
    logic          tag_q;
    logic          gnt0_c;
    logic          gnt1_c;
    logic          accept_c;
    logic          rsp_hs_c;

    // Grant: on a tie the pointer requester wins (round-robin) or requester 0 wins (fixed).
`ifdef CORDIC_SCHED_RR_EN
    logic ptr_q;
    assign gnt0_c = req0_valid && (!req1_valid || !ptr_q);
    assign gnt1_c = req1_valid && (!req0_valid ||  ptr_q);
`else
    assign gnt0_c = req0_valid;
    assign gnt1_c = req1_valid && !req0_valid;
`endif

    assign accept_c = (state == S_IDLE) && reset && (gnt0_c || gnt1_c);
    assign rsp_hs_c = (state == S_RESP) && (tag_q ? rsp1_ready : rsp0_ready);
    assign eng_angle = angle_q;
    assign rsp_cos   = result_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        eng_reset  = !reset;
        eng_clk_en = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                req0_ready = gnt0_c && reset;
                req1_ready = gnt1_c && reset;
                if (accept_c) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                eng_reset = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                eng_clk_en = 1'b1;
                if (cnt_q == '0) state_nxt = S_CAP;
            end
            S_CAP: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = !tag_q;
                rsp1_valid = tag_q;
                if (rsp_hs_c) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction datapath: latched request, iteration counter, captured result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            angle_q  <= '0;
            tag_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept_c) begin
                angle_q <= gnt0_c ? req0_angle : req1_angle;
                tag_q   <= !gnt0_c;
            end
            if (state == S_LOAD) begin
                cnt_q <= CW'(ENGINE_CYCLES - 1);
            end else if ((state == S_RUN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state == S_CAP) begin
                result_q <= eng_cos;
            end
        end
    end

`ifdef CORDIC_SCHED_RR_EN
    // After a completed response the other requester takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (rsp_hs_c) begin
            ptr_q <= !tag_q;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_cos_sched.sv
// Bench for cordic_cos_sched: behavioural engine, transaction-level reference model, random traffic.
module tb_cordic_cos_sched;

    localparam int unsigned W  = 22;
    localparam int          EC = 4;
`ifdef CORDIC_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_angle, req1_angle;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_cos, eng_angle, eng_cos;
    logic         eng_reset, eng_clk_en, busy;

    always #5 clk = ~clk;

    cordic_cos_sched #(.W(W), .ENGINE_CYCLES(EC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_cos(rsp_cos), .eng_reset(eng_reset), .eng_clk_en(eng_clk_en),
        .eng_angle(eng_angle), .eng_cos(eng_cos), .busy(busy)
    );

    function automatic logic [W-1:0] ref_cos(input logic [W-1:0] a);
        return W'(a * 22'd40503) ^ 22'h2AAAAA ^ W'(a >> 5);
    endfunction

    // Engine: correct only after exactly EC enabled iterations since the last reload.
    logic [W-1:0] eng_a;
    logic [3:0]   eng_it;
    always_ff @(posedge clk) begin
        if (eng_reset) begin
            eng_a  <= eng_angle;
            eng_it <= 4'd0;
        end else if (eng_clk_en && eng_it != 4'hF) begin
            eng_it <= eng_it + 4'd1;
        end
    end
    assign eng_cos = (eng_it == 4'(EC)) ? ref_cos(eng_a) : ~ref_cos(eng_a);

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: at most one transaction in flight.
    bit           busy_m = 1'b0;
    bit           tag_m = 1'b0;
    bit           ptr_m = 1'b0;
    bit           acc_pred0 = 1'b0, acc_pred1 = 1'b0;
    int           acc_cyc = 0;
    int           n_acc = 0, n_rsp = 0, n_drop = 0;
    logic [W-1:0] ang_m;
    bit           order_q[$];

    always @(negedge clk) begin : mon
        logic [6:0] obs_v, exp_v;
        bit         w0, w1;
        int         k;
        cyc++;
        acc_pred0 = 1'b0;
        acc_pred1 = 1'b0;
        obs_v = {busy, req0_ready, req1_ready, eng_reset, eng_clk_en, rsp0_valid, rsp1_valid};
        if (!reset) begin
            if (busy_m) n_drop++;
            busy_m = 1'b0;
            ptr_m  = 1'b0;
            check_eq("reset_outs", obs_v, 7'b0001000);
        end else if (!busy_m) begin
            if (req0_valid && req1_valid) begin
                w1 = RR_EN && ptr_m;
                w0 = !w1;
            end else begin
                w0 = req0_valid;
                w1 = req1_valid;
            end
            exp_v = {1'b0, w0, w1, 4'b0000};
            check_eq("idle_outs", obs_v, exp_v);
            if (w0 || w1) begin
                busy_m  = 1'b1;
                acc_cyc = cyc;
                tag_m   = w1;
                ang_m   = w1 ? req1_angle : req0_angle;
                acc_pred0 = w0;
                acc_pred1 = w1;
                n_acc++;
                order_q.push_back(w1);
            end
        end else begin
            k = cyc - acc_cyc;
            exp_v = {1'b1, 1'b0, 1'b0, k == 1, (k >= 2) && (k <= 1 + EC),
                     (k >= 3 + EC) && !tag_m, (k >= 3 + EC) && tag_m};
            check_eq("busy_outs", obs_v, exp_v);
            if (k >= 3 + EC) begin
                check_eq("rsp_cos", rsp_cos, ref_cos(ang_m));
                if (tag_m ? rsp1_ready : rsp0_ready) begin
                    busy_m = 1'b0;
                    n_rsp++;
                    if (RR_EN) ptr_m = !tag_m;
                end
            end
        end
    end

    int mode = 0;

    task automatic rnd_req(input bit acc, inout logic v, inout logic [W-1:0] a);
        if (v) begin
            if (acc) begin
                v = 1'($urandom_range(0, 1));
                a = W'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                v = 1'b0;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            v = 1'b1;
            a = W'($urandom);
        end
    endtask

    // One clock; then inputs change according to the current stimulus mode.
    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0: begin
                if (acc_pred0) req0_valid = 1'b0;
                if (acc_pred1) req1_valid = 1'b0;
            end
            1: begin
                if (acc_pred0) req0_angle = W'($urandom);
                if (acc_pred1) req1_angle = W'($urandom);
            end
            default: begin
                rnd_req(acc_pred0, req0_valid, req0_angle);
                rnd_req(acc_pred1, req1_valid, req1_angle);
                rsp0_ready = ($urandom_range(0, 2) != 0);
                rsp1_ready = ($urandom_range(0, 2) != 0);
            end
        endcase
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        mode = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        while (busy_m && b < 40) begin
            tick();
            b++;
        end
        check_eq(tag, busy_m, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        int b, save;
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = '0;
        req1_angle = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        mode = 0;
        repeat (3) tick();

        // Single request for angle 0, accepted in the first cycle after release.
        reset = 1'b1;
        req1_valid = 1'b0;
        save = n_rsp;
        b = 0;
        while (n_rsp == save && b < 30) begin
            tick();
            b++;
        end
        check_eq("single_rsp", n_rsp, save + 1);
        drain("single_drain");

        // Both requesters continuously valid for four transactions.
        pulse_reset();
        order_q.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = W'($urandom);
        req1_angle = W'($urandom);
        mode = 1;
        b = 0;
        while (order_q.size() < 4 && b < 60) begin
            tick();
            b++;
        end
        check_eq("order_len", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check_eq("order_tag", order_q[i], RR_EN ? (i % 2) : 0);
        drain("order_drain");

        // Back-pressured response while the other requester waits.
        req0_valid = 1'b1;
        req0_angle = W'($urandom);
        rsp0_ready = 1'b0;
        b = 0;
        while (!rsp0_valid && b < 20) begin
            tick();
            if (acc_pred0) begin
                req1_valid = 1'b1;
                req1_angle = W'($urandom);
            end
            b++;
        end
        check_eq("hold_reach", rsp0_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_valid", rsp0_valid, 1'b1);
            check_eq("hold_r1_ready", req1_ready, 1'b0);
        end
        rsp0_ready = 1'b1;
        save = n_rsp;
        b = 0;
        while (n_rsp < save + 2 && b < 30) begin
            tick();
            b++;
        end
        check_eq("hold_both_rsp", n_rsp, save + 2);
        drain("hold_drain");

        // Reset during a requester-1 computation, then a tie.
        req1_valid = 1'b1;
        req1_angle = W'($urandom);
        b = 0;
        while (!eng_clk_en && b < 20) begin
            tick();
            b++;
        end
        check_eq("run_reach", eng_clk_en, 1'b1);
        tick();
        pulse_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = W'($urandom);
        req1_angle = W'($urandom);
        save = n_acc;
        b = 0;
        while (n_acc == save && b < 10) begin
            tick();
            b++;
        end
        check_eq("tie_after_reset_acc", n_acc, save + 1);
        if (order_q.size() > 0) check_eq("tie_after_reset_tag", order_q[$], 1'b0);
        drain("reset_drain");

        // Random traffic.
        mode = 2;
        repeat (10000) tick();
        drain("random_drain");

        check_eq("scoreboard", n_acc, n_rsp + n_drop);
        check_eq("drops", n_drop, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_cos_sched.md
CORDIC_COS_SCHED -- requirements
Module: cordic_cos_sched

Interface
REQ-001 Parameter: W, 22, angle/result width in bits, matching the cosine engine.
REQ-002 Parameter: ENGINE_CYCLES, 4, engine clock-enable cycles needed per computation.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_valid / req1_valid  input  1  requester k has an angle pending.
REQ-006 Port: req0_angle / req1_angle  input  W  angle from requester k, held stable while valid.
REQ-007 Port: req0_ready / req1_ready  output  1  request k accepted this cycle when valid and ready are both high.
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  result available for requester k.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester k consumes the result.
REQ-010 Port: rsp_cos  output  W  result word, shared by both response channels.
REQ-011 Port: eng_reset  output  1  active-high reload strobe to the cosine engine.
REQ-012 Port: eng_clk_en  output  1  engine iteration enable.
REQ-013 Port: eng_angle  output  W  angle presented to the engine.
REQ-014 Port: eng_cos  input  W  engine cosine output.
REQ-015 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-016 FSM states: IDLE, LOAD, RUN, CAP, RESP; encoding is free.
REQ-017 IDLE: the grant is computed combinationally from the valids and the priority pointer; only the granted requester's ready is high; all readys are low outside IDLE.
REQ-018 Accept (valid && ready in cycle C): latch the angle and the 1-bit requester tag; next state is LOAD.
REQ-019 LOAD (cycle C+1): eng_reset=1, eng_clk_en=0, eng_angle = latched angle; next state is RUN.
REQ-020 RUN (cycles C+2 to C+1+ENGINE_CYCLES): eng_clk_en=1 and a down-counter loaded with ENGINE_CYCLES-1 decrements each cycle; at zero, next state is CAP.
REQ-021 CAP (cycle C+2+ENGINE_CYCLES): register eng_cos into the result register; eng_clk_en=0; next state is RESP.
REQ-022 RESP: rsp_cos = result register; rspk_valid=1 only for the latched tag; when rspk_ready is high, next state is IDLE and the pointer updates.
REQ-023 Latency at default parameters: accept in cycle C gives the first rsp_valid in C+7; back-to-back accept spacing is at least 8 cycles with a 0-wait responder.
REQ-024 eng_clk_en is 0 in IDLE, LOAD, CAP and RESP; eng_angle is held during RUN.
REQ-025 The engine done signal is not used; completion is determined only by the cycle counter.
REQ-026 rsp_valid, once high, stays high with rsp_cos stable until the handshake completes; exactly one response is returned per accepted request.
REQ-027 A requester dropping valid before acceptance gets no response; valids arriving outside IDLE wait and are not lost.
REQ-028 Both valids high in IDLE: the winner is chosen by the policy in REQ-034 or REQ-035.

Reset
REQ-029 Reset low immediately forces state IDLE, the pointer to 0 (requester 0 first), counter 0, result register 0 and tag 0.
REQ-030 While reset is low: all ready and rsp_valid outputs are 0, eng_clk_en=0, eng_reset=1, busy=0.
REQ-031 Reset asserted mid-computation or mid-response discards that transaction; no response is issued after reset is released.
REQ-032 After release, the first accept is possible in the first clock cycle in which reset is high.

Configuration
REQ-033 Macro: CORDIC_SCHED_RR_EN selects the arbitration policy.
REQ-034 Defined: round-robin; after each completed response the pointer is set to the other requester, and the pointer requester wins a tie.
REQ-035 Undefined: fixed priority; requester 0 always wins a tie and the pointer logic is absent.

Verification
REQ-036 req0 angle 0 alone -> req0_ready in C, eng_reset in C+1, eng_clk_en in C+2..C+5, rsp0_valid in C+7, rsp_cos equal to the engine output for angle 0.
REQ-037 Both valids held high for 4 transactions, rsp always ready -> with RR_EN, order 0,1,0,1; without it, 0,0,0,0.
REQ-038 rsp0_ready held low for 10 cycles -> rsp0_valid and rsp_cos stable for all 10 cycles; req1 ready stays 0 until the handshake completes.
REQ-039 reset pulsed low during RUN of a req1 transaction -> outputs cleared in that cycle; rsp1_valid never asserted; the next accept goes to req0 on a tie.
REQ-040 Random valid drop/re-assert with random rsp_ready (10k cycles) -> scoreboard shows 1:1 accept-to-response, correct tag routing, and no eng_clk_en outside RUN.
